// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - glitch-free PWM output stage for the six on-board LEDs
//
// Purpose:
//   Takes a 6-bit LED pattern over a valid/ready handshake into a one-entry
//   shadow register and promotes it to the active pattern only at PWM period
//   boundaries. Lit LEDs are modulated by a global duty that is either the
//   static brightness or an automatic breathing ramp capped by brightness.
//
// Optional feature macro: LED_GAMMA_EN
//   Defined:   duty = (d*d) >> PWM_W (quadratic perceptual correction)
//   Undefined: duty = d (linear)
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   pattern       in   [5:0] LED pattern, 1 = LED enabled
//   pattern_vld   in   pattern valid this cycle
//   pattern_rdy   out  shadow register empty (registered)
//   mode          in   0 = static brightness, 1 = breathing
//   brightness    in   [PWM_W-1:0] static duty or breathing ceiling
//   led           out  [5:0] LED pins, polarity set by ACTIVE_LOW
//   period_start  out  pulse in the first output cycle of each PWM period

module led_pwm_driver #(
  parameter int PWM_W      = 8,
  parameter int FADE_DIV   = 64,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       pattern,
  input  logic             pattern_vld,
  output logic             pattern_rdy,
  input  logic             mode,
  input  logic [PWM_W-1:0] brightness,
  output logic [5:0]       led,
  output logic             period_start
);

  localparam int STEP_W = $clog2(FADE_DIV + 1);

  localparam logic [1:0] ST_STATIC    = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd2;

  localparam logic [5:0] LED_OFF = ACTIVE_LOW ? 6'h3f : 6'h00;

  // Registered state
  logic [PWM_W-1:0]  pwm_cnt;
  logic [5:0]        active;
  logic [5:0]        shadow;
  logic              shadow_full;
  logic [PWM_W-1:0]  level;
  logic [1:0]        state;
  logic [STEP_W-1:0] step_cnt;
  logic [PWM_W-1:0]  duty;

  // Next-state values, only committed at a boundary
  logic              boundary;
  logic              accept;
  logic              step_hit;
  logic [PWM_W:0]    level_inc;
  logic [1:0]        state_nxt;
  logic [PWM_W-1:0]  level_nxt;
  logic [STEP_W-1:0] step_nxt;
  logic [PWM_W-1:0]  d_sel;
  logic [PWM_W-1:0]  duty_nxt;

  // Output path
  logic [5:0]        eff_active;
  logic [PWM_W-1:0]  eff_duty;
  logic              on;
  logic [5:0]        lit;
  logic [5:0]        led_nxt;

  assign boundary    = (pwm_cnt == '0);
  assign pattern_rdy = ~shadow_full;
  assign accept      = pattern_vld & ~shadow_full;

  // Breathing state machine. A step fires every FADE_DIV boundaries; the
  // direction flip happens on the same step that reaches the end value, so
  // the peak and the floor each last exactly one step.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    step_nxt  = step_cnt;
    step_hit  = (step_cnt == STEP_W'(FADE_DIV - 1));
    level_inc = {1'b0, level} + (PWM_W + 1)'(1);

    case (state)
      ST_STATIC: begin
        if (mode) begin
          state_nxt = ST_RAMP_UP;
          level_nxt = '0;
          step_nxt  = '0;
        end
      end

      ST_RAMP_UP: begin
        if (!mode) begin
          state_nxt = ST_STATIC;
          level_nxt = '0;
          step_nxt  = '0;
        end else if (step_hit) begin
          step_nxt = '0;
          // Also clamps when brightness was lowered below the current level
          if (level_inc >= {1'b0, brightness}) begin
            level_nxt = brightness;
            state_nxt = ST_RAMP_DOWN;
          end else begin
            level_nxt = level_inc[PWM_W-1:0];
          end
        end else begin
          step_nxt = step_cnt + STEP_W'(1);
        end
      end

      ST_RAMP_DOWN: begin
        if (!mode) begin
          state_nxt = ST_STATIC;
          level_nxt = '0;
          step_nxt  = '0;
        end else if (step_hit) begin
          step_nxt = '0;
          // level 0 here only happens with brightness 0: stay at 0, flip
          if (level <= PWM_W'(1)) begin
            level_nxt = '0;
            state_nxt = ST_RAMP_UP;
          end else begin
            level_nxt = level - PWM_W'(1);
          end
        end else begin
          step_nxt = step_cnt + STEP_W'(1);
        end
      end

      default: begin
        state_nxt = ST_STATIC;
        level_nxt = '0;
        step_nxt  = '0;
      end
    endcase
  end

  // Duty source follows the state being entered, so leaving breathing shows
  // the static brightness in the very next period and entering it starts at 0.
  assign d_sel = mode ? level_nxt : brightness;

`ifdef LED_GAMMA_EN
  logic [2*PWM_W-1:0] d_sq;

  always_comb begin
    d_sq     = {{PWM_W{1'b0}}, d_sel} * {{PWM_W{1'b0}}, d_sel};
    duty_nxt = PWM_W'(d_sq >> PWM_W);
  end
`else
  assign duty_nxt = d_sel;
`endif

  // In the boundary cycle the led flop already loads the first sample of the
  // new period, so it must see the pattern and duty being committed there.
  // This keeps every period uniform: no single stale cycle at its start.
  assign eff_active = (boundary && shadow_full) ? shadow : active;
  assign eff_duty   = boundary ? duty_nxt : duty;
  assign on         = (pwm_cnt < eff_duty);
  assign lit        = eff_active & {6{on}};
  assign led_nxt    = ACTIVE_LOW ? ~lit : lit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt      <= '0;
      active       <= '0;
      shadow       <= '0;
      shadow_full  <= 1'b0;
      level        <= '0;
      state        <= ST_STATIC;
      step_cnt     <= '0;
      duty         <= '0;
      led          <= LED_OFF;
      period_start <= 1'b0;
    end else begin
      pwm_cnt      <= pwm_cnt + PWM_W'(1);
      period_start <= boundary;
      led          <= led_nxt;

      // accept requires an empty shadow, so it never collides with promotion
      if (accept) begin
        shadow      <= pattern;
        shadow_full <= 1'b1;
      end else if (boundary && shadow_full) begin
        active      <= shadow;
        shadow_full <= 1'b0;
      end

      if (boundary) begin
        state    <= state_nxt;
        level    <= level_nxt;
        step_cnt <= step_nxt;
        duty     <= duty_nxt;
      end
    end
  end

endmodule
